// File: rtl/pipe_stage_latch_if.sv
// Handshake bundle between a pipeline stage latch and its neighbours.
// The slave modport is the stage's own view; master is the surrounding datapath.
interface pipe_stage_latch_if #(
  parameter int DATA_W = 64
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [1:0]        o_occupancy;

  modport slave (
    input  i_flush, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_occupancy
  );

  modport master (
    output i_flush, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_occupancy
  );
endinterface

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline register with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer with a registered o_ready.
module pipe_stage_latch #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stage_latch_if.slave    bus
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
`endif

  logic stageValid;
  logic stageReady;
  logic inXfer;
  logic outXfer;

  assign stageValid = (state_q != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
  assign stageReady = (state_q != FULL);
`else
  // Without a skid slot the stage may only refill when its payload leaves this cycle.
  assign stageReady = ~stageValid | bus.i_ready;
`endif

  assign inXfer  = bus.i_valid & stageReady;
  assign outXfer = stageValid & bus.i_ready;

  assign bus.o_valid     = stageValid;
  assign bus.o_ready     = stageReady;
  assign bus.o_data      = main_q;
  assign bus.o_occupancy = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (bus.i_flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = RESET_VAL;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (inXfer) begin
            main_d  = bus.i_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (inXfer && outXfer) begin
            main_d = bus.i_data;
          end else if (outXfer) begin
            state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (inXfer) begin
            skid_d  = bus.i_data;
            state_d = FULL;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (outXfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= RESET_VAL;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
- Generalised inter-stage pipeline register for the processor datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces fixed-width, always-loading stage latches with a DATA_W-wide stage that carries a valid bit and a valid/ready handshake.
- Adds stall back-pressure, flush (bubble insertion) and an optional one-entry skid buffer, so a stage can hold its contents without losing upstream data.

Parameters:
- DATA_W, 64, width of the stage payload in bits.
- RESET_VAL, 0, value loaded into every data register on reset and on flush.

Ports:
- clk  input  1  stage clock; all state updates on the falling edge of clk.
- rst  input  1  reset, synchronous, active-low.
- i_flush  input  1  discard all stage contents (branch/jump/exception squash).
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  stage can accept a payload this cycle.
- i_data  input  DATA_W  upstream payload.
- o_valid  output  1  downstream payload valid.
- i_ready  input  1  downstream accepts the payload this cycle.
- o_data  output  DATA_W  payload presented downstream.
- o_occupancy  output  2  number of payloads held: 0, 1 or 2.

Behaviour:
- Edges and reset:
  - All registers update on the falling edge of clk only.
  - rst is sampled on that same edge.
  - Reset state: EMPTY; main and skid data = RESET_VAL; o_valid=0; o_ready=1; o_occupancy=0; o_data=RESET_VAL.
- Transfers:
  - Input transfer IN = i_valid & o_ready.
  - Output transfer OUT = o_valid & i_ready.
- Outputs:
  - o_data is driven from the main register; o_valid = (state != EMPTY).
- Latency:
  - A payload accepted at edge N appears on o_data/o_valid after edge N, i.e. one edge of latency.
  - Throughput is one payload per cycle when i_ready=1.
- State machine, with skid buffer compiled in:
  - EMPTY (o_ready=1):
    - IN: main<=i_data, go to BUSY.
    - Otherwise hold.
  - BUSY (o_ready=1):
    - IN&OUT: main<=i_data, stay in BUSY.
    - IN&~OUT: skid<=i_data, go to FULL.
    - ~IN&OUT: go to EMPTY.
    - Neither: hold.
  - FULL (o_ready=0, registered):
    - OUT: main<=skid, go to BUSY.
    - Otherwise hold.
    - IN cannot occur in this state.
- o_occupancy: EMPTY=0, BUSY=1, FULL=2.
- Stall: with i_ready=0 the main register and o_valid are held stable indefinitely, and o_data does not change while o_valid=1 and i_ready=0.
- Data in EMPTY: o_data keeps its last value, which downstream treats as don't-care. It is cleared only by reset or flush.
- Flush:
  - i_flush=1 at an edge forces EMPTY and loads RESET_VAL into main and skid.
  - Any simultaneous IN is discarded.
  - Priority: rst > i_flush > handshake.
- Reset during operation: a payload held in main or skid is lost. o_valid=0 takes effect immediately after the reset edge.
- Upstream protocol: i_data must be stable while i_valid=1 and o_ready=0. The block does not check this.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined: the three-state behaviour above; o_ready is registered (= state != FULL).
- Undefined:
  - No skid register. o_ready = ~o_valid | i_ready, which is combinational from i_ready.
  - The FULL state does not exist and o_occupancy never exceeds 1.
  - In BUSY: IN&~OUT cannot occur. IN&OUT loads main. ~IN&OUT goes to EMPTY.

Test Plan:
- Reset: rst=0 for 2 edges with i_valid=1, i_data=64'hDEAD -> o_valid=0, o_data=0, o_ready=1, o_occupancy=0.
- Streaming: i_ready=1, i_valid=1, i_data=1,2,3,4 on consecutive edges -> o_data=1,2,3,4 one edge later, o_valid=1 throughout, o_occupancy=1.
- Stall with skid (PIPE_STAGE_SKID_EN):
  - Send A=0xA, then B=0xB, with i_ready=0 -> o_data=0xA held, o_occupancy=2, o_ready=0.
  - Release i_ready -> o_data=0xA then 0xB; o_ready=1 one edge after the first OUT.
- Flush: in FULL with A/B held, i_flush=1 with i_valid=1, i_data=0xC -> next edge o_valid=0, o_occupancy=0, o_data=0, and 0xC never appears.
- No-skid build: i_valid=1, i_ready=0, stage BUSY -> o_ready=0 in the same cycle. Raise i_ready -> o_ready=1 combinationally and the new data loads at the next edge.
- Reset during operation: in BUSY with o_data=0x55, assert rst for one edge while i_valid=1 -> o_valid=0, o_data=0. After rst is released the stage accepts new data normally.
